// File: rtl/multdiv_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (non-restoring); result WIDTH+1 cycles after start, busy stalls decode.
// Build option MULTDIV_EARLY_DIV0_EN: divide-by-zero completes two cycles after start instead of the full iteration run.
module multdiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH+1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   mq_q, mq_d;
  logic               qm1_q, qm1_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               dexc_q, dexc_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               exc_q, exc_d;
  logic               rdy_q, rdy_d;

  logic               start_mul, start_div;
  logic [WIDTH-1:0]   a_mag, b_mag, quot;
  logic [WIDTH+1:0]   booth_ext, div_ext, shifted, step_sum;
  logic [2*WIDTH-1:0] product;
  logic               mul_ovf;

  // Simultaneous start pulses are ignored entirely.
  assign start_mul = ctrl_MULT & ~ctrl_DIV;
  assign start_div = ctrl_DIV & ~ctrl_MULT;

  assign a_mag     = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign b_mag     = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
  assign booth_ext = {{2{opnd_q[WIDTH-1]}}, opnd_q};
  assign div_ext   = {2'b00, opnd_q};
  assign shifted   = {acc_q[WIDTH:0], mq_q[WIDTH-1]};
  assign product   = {acc_q[WIDTH-1:0], mq_q};
  assign mul_ovf   = ~((&product[2*WIDTH-1:WIDTH-1]) | ~(|product[2*WIDTH-1:WIDTH-1]));
  assign quot      = neg_q ? -mq_q : mq_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mq_d     = mq_q;
    qm1_d    = qm1_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    dexc_d   = dexc_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
    step_sum = acc_q;

    case (state_q)
      S_MUL: begin
        case ({mq_q[0], qm1_q})
          2'b01:   step_sum = acc_q + booth_ext;
          2'b10:   step_sum = acc_q - booth_ext;
          default: step_sum = acc_q;
        endcase
        acc_d = {step_sum[WIDTH+1], step_sum[WIDTH+1:1]};
        mq_d  = {step_sum[0], mq_q[WIDTH-1:1]};
        qm1_d = mq_q[0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_IT) state_d = S_DONE;
      end
      S_DIV: begin
        // Partial remainder sign picks add-back vs subtract; quotient bit is its complement.
        step_sum = acc_q[WIDTH+1] ? (shifted + div_ext) : (shifted - div_ext);
        acc_d    = step_sum;
        mq_d     = {mq_q[WIDTH-2:0], ~step_sum[WIDTH+1]};
        cnt_d    = cnt_q + CNT_W'(1);
`ifdef MULTDIV_EARLY_DIV0_EN
        if ((cnt_q == LAST_IT) || (opnd_q == '0)) state_d = S_DONE;
`else
        if (cnt_q == LAST_IT) state_d = S_DONE;
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
        rdy_d   = 1'b1;
        if (is_div_q) begin
          result_d = dexc_q ? '0 : quot;
          exc_d    = dexc_q;
        end else begin
          result_d = product[WIDTH-1:0];
          exc_d    = mul_ovf;
        end
      end
      default: ;
    endcase

    // A start in any state restarts; the aborted op never raises RDY.
    if (start_mul || start_div) begin
      state_d  = start_mul ? S_MUL : S_DIV;
      cnt_d    = '0;
      acc_d    = '0;
      qm1_d    = 1'b0;
      rdy_d    = 1'b0;
      result_d = result_q;
      exc_d    = exc_q;
      is_div_d = start_div;
      mq_d     = start_mul ? data_operandB : a_mag;
      opnd_d   = start_mul ? data_operandA : b_mag;
      neg_d    = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      dexc_d   = (data_operandB == '0) ||
                 ((data_operandA == INT_MIN) && (data_operandB == '1));
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mq_q     <= '0;
      qm1_q    <= 1'b0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      dexc_q   <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mq_q     <= mq_d;
      qm1_q    <= qm1_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      dexc_q   <= dexc_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed and randomized bench for multdiv_unit against an arithmetic reference model.
module tb_multdiv_unit;

  logic        clock = 1'b0;
  logic        resetn;
  logic [31:0] data_operandA, data_operandB;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY, busy;

  int errors = 0;
  int checks = 0;

`ifdef MULTDIV_EARLY_DIV0_EN
  localparam int DIV0_LAT = 2;
`else
  localparam int DIV0_LAT = 33;
`endif
  localparam int OP_LAT = 33;

  multdiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clock          (clock),
    .resetn         (resetn),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: full-precision product and truncating division in plain integer arithmetic.
  function automatic void model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e);
    longint p;
    int     q;
    if (!is_div) begin
      p = longint'($signed(a)) * longint'($signed(b));
      r = p[31:0];
      e = (p != longint'($signed(p[31:0])));
    end else if (b == 32'd0 || (a == 32'h80000000 && b == 32'hFFFFFFFF)) begin
      r = 32'd0;
      e = 1'b1;
    end else begin
      q = $signed(a) / $signed(b);
      r = q;
      e = 1'b0;
    end
  endfunction

  task automatic run_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r, input logic exp_e, input int exp_lat,
                        input string tag);
    int          lat;
    bit          held;
    logic [31:0] prev;
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = !is_div;
    ctrl_DIV      = is_div;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    prev      = data_result;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    lat  = 0;
    held = 1'b1;
    for (int n = 1; n <= 80 && lat == 0; n++) begin
      @(negedge clock);
      if (data_resultRDY) lat = n;
      else if (data_result !== prev) held = 1'b0;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_busy_at_rdy"}, 64'(busy), 64'd0);
    check({tag, "_result"}, 64'(data_result), 64'(exp_r));
    check({tag, "_exception"}, 64'(data_exception), 64'(exp_e));
    check({tag, "_held"}, 64'(held), 64'd1);
    @(negedge clock);
    check({tag, "_rdy_pulse"}, 64'(data_resultRDY), 64'd0);
  endtask

  initial begin
    int          rdy_cnt;
    int          first_n;
    logic [31:0] prev;
    logic [31:0] ra, rb, rr;
    logic        re;
    bit          rd;

    resetn        = 1'b0;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (2) @(negedge clock);
    check("reset_result", 64'(data_result), 64'd0);
    check("reset_exc", 64'(data_exception), 64'd0);
    check("reset_rdy", 64'(data_resultRDY), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    resetn = 1'b1;

    run_op(1'b0, 32'd7, 32'hFFFFFFFA, 32'hFFFFFFD6, 1'b0, OP_LAT, "mul_7x-6");
    run_op(1'b0, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1, OP_LAT, "mul_ovf");
    run_op(1'b0, 32'h80000000, 32'd1, 32'h80000000, 1'b0, OP_LAT, "mul_min_x1");
    run_op(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, OP_LAT, "div_-7/2");
    run_op(1'b1, 32'd100, 32'd7, 32'd14, 1'b0, OP_LAT, "div_100/7");
    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b1, OP_LAT, "div_min/-1");
    run_op(1'b1, 32'd5, 32'd0, 32'd0, 1'b1, DIV0_LAT, "div_by0");

    // Both start pulses together: nothing should happen.
    @(negedge clock);
    prev          = data_result;
    data_operandA = 32'd9;
    data_operandB = 32'd9;
    ctrl_MULT     = 1'b1;
    ctrl_DIV      = 1'b1;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    check("both_busy", 64'(busy), 64'd0);
    rdy_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clock);
      if (data_resultRDY) rdy_cnt++;
    end
    check("both_no_rdy", 64'(rdy_cnt), 64'd0);
    check("both_result_held", 64'(data_result), 64'(prev));

    // Restart: 3*3 at edge 0, 10/3 at edge 10; only the divide completes, at edge 43.
    @(negedge clock);
    data_operandA = 32'd3;
    data_operandB = 32'd3;
    ctrl_MULT     = 1'b1;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    rdy_cnt   = 0;
    first_n   = 0;
    for (int n = 1; n <= 70; n++) begin
      @(negedge clock);
      if (data_resultRDY) begin
        rdy_cnt++;
        if (first_n == 0) first_n = n;
      end
      if (n == 9) begin
        data_operandA = 32'd10;
        data_operandB = 32'd3;
        ctrl_DIV      = 1'b1;
      end
      if (n == 10) ctrl_DIV = 1'b0;
      if (first_n == n) check("restart_result", 64'(data_result), 64'd3);
    end
    check("restart_rdy_count", 64'(rdy_cnt), 64'd1);
    check("restart_rdy_cycle", 64'(first_n), 64'd43);

    // Asynchronous reset mid-multiply.
    @(negedge clock);
    data_operandA = 32'h1234;
    data_operandB = 32'h10;
    ctrl_MULT     = 1'b1;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    repeat (4) @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    check("arst_result", 64'(data_result), 64'd0);
    check("arst_exc", 64'(data_exception), 64'd0);
    check("arst_rdy", 64'(data_resultRDY), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    @(negedge clock);
    resetn  = 1'b1;
    rdy_cnt = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clock);
      if (data_resultRDY) rdy_cnt++;
    end
    check("arst_no_rdy", 64'(rdy_cnt), 64'd0);
    run_op(1'b0, 32'h1234, 32'h10, 32'h12340, 1'b0, OP_LAT, "post_reset_mul");

    for (int i = 0; i < 24; i++) begin
      rd = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 4))
        0: rb = 32'($urandom_range(0, 20));
        1: rb = 32'd0 - 32'($urandom_range(1, 20));
        2: ra = 32'h80000000;
        3: begin
          ra = ra >> $urandom_range(8, 24);
          rb = rb >> $urandom_range(8, 24);
        end
        default: ;
      endcase
      model(rd, ra, rb, rr, re);
      run_op(rd, ra, rb, rr, re, (rd && rb == 32'd0) ? DIV0_LAT : OP_LAT, rd ? "rand_div" : "rand_mul");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
